// File: rtl/sdpram_wr_ctrl.sv
// Write-port controller for the 1024x8 simple dual-port RAM: pattern fill or stream fill.
// Optional frame checksum adder is built only when SDPRAM_WR_CSUM_EN is defined.
module sdpram_wr_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  wr_clk,
    input  logic                  tb_wr_rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  rd_ack,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [ADDR_WIDTH:0]   frame_len,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] csum
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_C  = DEPTH_C - 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] pat_q, pat_d;
    logic                  last_q, last_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  beat;
    logic [DATA_WIDTH-1:0] beat_data;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        last_d    = last_q;
        ovf_d     = ovf_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        s_ready   = 1'b0;
        beat      = 1'b0;
        beat_data = s_data;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    last_d  = 1'b0;
                    pat_d   = '1;
                    state_d = mode ? S_STREAM : S_FILL;
                end
            end
            S_FILL: begin
                if (cnt_q == DEPTH_C) begin
                    state_d = S_DONE;
                end else begin
                    beat      = 1'b1;
                    beat_data = pat_q;
                    pat_d     = pat_q - 1'b1;
                end
            end
            S_STREAM: begin
                // last_q gives one idle cycle so the final write commits before DONE
                if (last_q) begin
                    state_d = S_DONE;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        beat = 1'b1;
                        if (s_last || cnt_q == LAST_C) last_d = 1'b1;
                        if (!s_last && cnt_q == LAST_C) ovf_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (rd_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (beat) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
            wr_data_d = beat_data;
            cnt_d     = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pat_q     <= '0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef SDPRAM_WR_CSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (state_q == S_IDLE && start) csum_d = '0;
        else if (beat) csum_d = csum_q + beat_data;
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) csum_q <= '0;
        else csum_q <= csum_d;
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

    // the beat counter doubles as the frame length, held until the next start
    assign frame_len  = cnt_q;
    assign overflow   = ovf_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

endmodule
